adder_tree_ctrl: RTL
====================

Name: adder_tree_ctrl

Overview:
- Sequencer for the pipelined signed adder tree. Accepts a job of cfg_len input beats and streams them into the tree through a valid/ready handshake.
- Drives the tree's en_advance and clear, and tracks in-flight beats with a STAGE_NUM-deep valid shadow register.
- Accumulates the tree outputs into one wide result per job and presents it on a valid/ready output with backpressure.
- Sits between the PE array output buffer and the output-channel writeback.

Parameters:
- DATA_WIDTH, 16, width of each tree input and of tree_sum (signed).
- PE_NUM, `HW_CONFIG_PE_NUM, number of tree inputs.
- STAGE_NUM, $clog2(PE_NUM), tree pipeline latency in en_advance cycles. 0 means a combinational tree.
- LEN_W, 16, width of cfg_len.
- ACC_WIDTH, 32, accumulator and result width (signed). Must be >= DATA_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  job request.
- cfg_ready  out  1  controller can accept a job.
- cfg_len  in  LEN_W  number of beats in the job (unsigned).
- in_valid  in  1  upstream beat available (PE_NUM operands already on the tree inputs).
- in_ready  out  1  beat accepted this cycle when in_valid && in_ready.
- tree_en_advance  out  1  to the tree's en_advance.
- tree_rst  out  1  to the tree's synchronous rst.
- tree_sum  in  DATA_WIDTH  tree adder_out (signed).
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_WIDTH  accumulated job result (signed).
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0) values:
  - state=IDLE; all counters, accumulator and valid shadow cleared to 0.
  - cfg_ready=1, in_ready=0, out_valid=0, out_data=0, busy=0.
  - tree_en_advance=0, tree_rst=1.
  - A reset mid-job drops the job silently; no partial result is ever emitted.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - cfg_ready=1, tree_rst=1, tree_en_advance=0. This clears the tree's pipeline registers.
  - On cfg_valid: latch cfg_len, zero issue_cnt, recv_cnt and acc.
  - If cfg_len==0: go to DONE with out_data=0. Otherwise go to RUN.
- RUN / DRAIN (shared rules):
  - tree_rst=0 and tree_en_advance=1 every cycle in these states. The result register is empty here, so there is no stall.
  - Each cycle the valid shadow vld[STAGE_NUM-1:0] shifts one stage toward the output. It is loaded with (in_valid && in_ready).
  - vld_out = vld[0]. When STAGE_NUM==0, vld_out = in_valid && in_ready in the same cycle.
- RUN only:
  - in_ready=1 while issue_cnt < len. Each handshake increments issue_cnt.
  - Handshake with issue_cnt==len-1 → DRAIN.
  - in_valid low inserts a bubble; the shadow carries a 0 for that slot.
- Accumulation (RUN and DRAIN):
  - On vld_out: acc <= acc + sign_extend(tree_sum) and recv_cnt++.
  - Sum wraps at ACC_WIDTH unless the Optional Feature is enabled.
- Job completion:
  - On vld_out with recv_cnt==len-1: out_data <= final sum, acc <= 0, go to DONE.
  - This can occur while still in RUN when STAGE_NUM==0.
  - The beat-to-contribution latency is exactly STAGE_NUM cycles. The result is registered 1 cycle after the last vld_out.
- DRAIN: in_ready=0.
- DONE:
  - out_valid=1; in_ready=0; cfg_ready=0; tree_en_advance=0; tree_rst=0.
  - On out_ready: go to IDLE. cfg_ready rises the next cycle; there is no same-cycle cfg accept.
  - out_data stays stable while out_valid=1 && !out_ready.
- Counters:
  - issue_cnt and recv_cnt are LEN_W+1 bits wide, so cfg_len = 2^LEN_W−1 does not wrap.
  - cfg_len is sampled only on the accept edge; later changes are ignored.

Optional Feature:
- Macro: ADDER_TREE_CTRL_SAT_EN.
- Defined:
  - The accumulator saturates at the signed ACC_WIDTH bounds instead of wrapping. The sum is computed at ACC_WIDTH+1 bits and clamped.
  - A sticky out_sat output (1 bit) is added. It is set if any clamp occurred in the job, valid with out_valid, and cleared on job accept.
- Undefined: wrap-around arithmetic and no out_sat port.

Test Plan:
- STAGE_NUM=3, cfg_len=4, in_valid held high, tree_sum = 10, 20, 30, 40 on successive vld_out → in_ready high exactly 4 cycles. out_valid rises 3+1 cycles after the last handshake with out_data=100. busy falls one cycle after out_ready.
- Same job with in_valid toggling 1,0,1,0,... → 4 handshakes over 7 cycles, bubbles not accumulated, out_data=100.
- cfg_len=0 → no in_ready pulse, out_valid with out_data=0 the cycle after accept.
- out_ready held low 5 cycles in DONE → out_valid and out_data stable, tree_en_advance=0, cfg_ready=0. Next job accepted only after the handshake.
- rst_n pulsed low mid-RUN after 2 of 4 beats → all outputs return to reset values immediately. No out_valid. A following cfg_len=1 job with tree_sum=−5 yields out_data=−5 (0xFFFFFFFB).
- With ADDER_TREE_CTRL_SAT_EN, ACC_WIDTH=16, DATA_WIDTH=16, 3 beats of tree_sum=0x7000 → out_data=0x7FFF, out_sat=1. Without the macro → out_data=0x5000 (wrapped).

Source files
------------

// File: rtl/adder_tree_ctrl_if.sv
// adder_tree_ctrl_if
// Groups the job-config, input-beat, tree-control and result signals of the
// adder tree sequencer into one bundle.
//   master : the controller side (drives cfg_ready, in_ready, tree_*, out_*, busy)
//   slave  : the environment side (PE buffer, tree, writeback)
// Signals:
//   cfg_valid/cfg_ready/cfg_len      job request handshake, cfg_len = beats
//   in_valid/in_ready                input beat handshake
//   tree_en_advance/tree_rst         tree pipeline control
//   tree_sum                         tree adder output (signed)
//   out_valid/out_ready/out_data     result handshake (signed result)
//   busy                             controller not idle
//   out_sat                          sticky saturation flag (ADDER_TREE_CTRL_SAT_EN only)
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// clk edge where both valid and ready are high; valid-side data must be held
// stable while valid is high and ready is low.
interface adder_tree_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_W      = 16,
  parameter int ACC_WIDTH  = 32
) ();
  logic                         cfg_valid;
  logic                         cfg_ready;
  logic [LEN_W-1:0]             cfg_len;
  logic                         in_valid;
  logic                         in_ready;
  logic                         tree_en_advance;
  logic                         tree_rst;
  logic signed [DATA_WIDTH-1:0] tree_sum;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [ACC_WIDTH-1:0]  out_data;
  logic                         busy;
`ifdef ADDER_TREE_CTRL_SAT_EN
  logic                         out_sat;

  modport master (
    input  cfg_valid, cfg_len, in_valid, tree_sum, out_ready,
    output cfg_ready, in_ready, tree_en_advance, tree_rst,
           out_valid, out_data, busy, out_sat
  );
  modport slave (
    output cfg_valid, cfg_len, in_valid, tree_sum, out_ready,
    input  cfg_ready, in_ready, tree_en_advance, tree_rst,
           out_valid, out_data, busy, out_sat
  );
`else
  modport master (
    input  cfg_valid, cfg_len, in_valid, tree_sum, out_ready,
    output cfg_ready, in_ready, tree_en_advance, tree_rst,
           out_valid, out_data, busy
  );
  modport slave (
    output cfg_valid, cfg_len, in_valid, tree_sum, out_ready,
    input  cfg_ready, in_ready, tree_en_advance, tree_rst,
           out_valid, out_data, busy
  );
`endif
endinterface

// File: rtl/adder_tree_ctrl.sv
// adder_tree_ctrl
// Sequencer for a pipelined signed adder tree. Accepts a job of cfg_len beats,
// streams them into the tree, tracks in-flight beats with a STAGE_NUM-deep
// valid shadow, accumulates the tree outputs and presents one result per job.
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset (drops any job in flight)
//   bus          adder_tree_ctrl_if.master (cfg, input beat, tree control,
//                result, busy)
//   o_dbg_state  current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
// Optional feature: define ADDER_TREE_CTRL_SAT_EN for a saturating
// accumulator plus the sticky bus.out_sat flag; otherwise the sum wraps.
`ifndef HW_CONFIG_PE_NUM
`define HW_CONFIG_PE_NUM 8
`endif

module adder_tree_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int PE_NUM     = `HW_CONFIG_PE_NUM,
  parameter int STAGE_NUM  = $clog2(PE_NUM),
  parameter int LEN_W      = 16,
  parameter int ACC_WIDTH  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  adder_tree_ctrl_if.master  bus,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

  state_t                      r_state;
  state_t                      w_next_state;
  // One extra bit so a job of 2^LEN_W-1 beats never wraps the counters.
  logic [LEN_W:0]              r_len;
  logic [LEN_W:0]              r_issue_cnt;
  logic [LEN_W:0]              r_recv_cnt;
  logic [LEN_W:0]              w_len_m1;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] r_out_data;
  logic signed [ACC_WIDTH-1:0] w_acc_next;
  logic                        w_active;
  logic                        w_accept;
  logic                        w_in_ready;
  logic                        w_hs;
  logic                        w_vld_out;
  logic                        w_last_recv;
  logic                        w_last_issue;
  logic                        w_cfg_ready;
  logic                        w_en_adv;
  logic                        w_tree_rst;
  logic                        w_out_valid;

  assign w_active     = (r_state == RUN) || (r_state == DRAIN);
  assign w_accept     = (r_state == IDLE) && bus.cfg_valid;
  assign w_in_ready   = (r_state == RUN) && (r_issue_cnt < r_len);
  assign w_hs         = bus.in_valid && w_in_ready;
  assign w_len_m1     = r_len - CNT_ONE;
  assign w_last_issue = w_hs && (r_issue_cnt == w_len_m1);
  assign w_last_recv  = w_active && w_vld_out && (r_recv_cnt == w_len_m1);

  // Valid shadow: a slot enters at the top when a beat is accepted and
  // reaches index 0 exactly when that beat's sum appears on tree_sum.
  generate
    if (STAGE_NUM == 0) begin : g_comb_tree
      assign w_vld_out = w_hs;
    end else begin : g_pipe_tree
      logic [STAGE_NUM-1:0] r_vld;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld <= '0;
        end else if (r_state == IDLE) begin
          r_vld <= '0;
        end else if (w_active) begin
          for (int i = 0; i < STAGE_NUM - 1; i++) begin
            r_vld[i] <= r_vld[i+1];
          end
          r_vld[STAGE_NUM-1] <= w_hs;
        end
      end
      assign w_vld_out = r_vld[0];
    end
  endgenerate

`ifdef ADDER_TREE_CTRL_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic signed [ACC_WIDTH:0] w_sum_ext;
  logic                      w_ovf;
  logic                      r_sat;

  // One guard bit: overflow shows up as the two top bits disagreeing.
  assign w_sum_ext = (ACC_WIDTH+1)'(r_acc) + (ACC_WIDTH+1)'(bus.tree_sum);
  assign w_ovf     = w_sum_ext[ACC_WIDTH] != w_sum_ext[ACC_WIDTH-1];
  assign w_acc_next = !w_ovf ? w_sum_ext[ACC_WIDTH-1:0] :
                      (w_sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (w_accept) begin
      r_sat <= 1'b0;
    end else if (w_active && w_vld_out && w_ovf) begin
      r_sat <= 1'b1;
    end
  end
  assign bus.out_sat = r_sat;
`else
  assign w_acc_next = r_acc + ACC_WIDTH'(bus.tree_sum);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cfg_ready  = 1'b0;
    w_en_adv     = 1'b0;
    w_tree_rst   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cfg_ready = 1'b1;
        w_tree_rst  = 1'b1;
        if (bus.cfg_valid) begin
          w_next_state = (bus.cfg_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        w_en_adv = 1'b1;
        // With a combinational tree the last beat completes the job directly.
        if (w_last_recv) begin
          w_next_state = DONE;
        end else if (w_last_issue) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        w_en_adv = 1'b1;
        if (w_last_recv) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_len       <= {1'b0, bus.cfg_len};
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_acc       <= '0;
      if (bus.cfg_len == '0) begin
        r_out_data <= '0;
      end
    end else if (w_active) begin
      if (w_hs) begin
        r_issue_cnt <= r_issue_cnt + CNT_ONE;
      end
      if (w_vld_out) begin
        r_recv_cnt <= r_recv_cnt + CNT_ONE;
        if (w_last_recv) begin
          r_out_data <= w_acc_next;
          r_acc      <= '0;
        end else begin
          r_acc <= w_acc_next;
        end
      end
    end
  end

  assign bus.cfg_ready       = w_cfg_ready;
  assign bus.in_ready        = w_in_ready;
  assign bus.tree_en_advance = w_en_adv;
  assign bus.tree_rst        = w_tree_rst;
  assign bus.out_valid       = w_out_valid;
  assign bus.out_data        = r_out_data;
  assign bus.busy            = (r_state != IDLE);
  assign o_dbg_state         = r_state;

endmodule
